// File: rtl/d_cache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with full-line refill,
// registered request/ready memory port, pipeline stall and saturating hit/miss counters.
module d_cache_wt #(
    parameter int unsigned SETS        = 16,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic                      wr_en,
    input  logic [31:0]               A,
    input  logic [31:0]               WD,
    output logic [31:0]               RD,
    output logic                      HIT,
    output logic                      STALL,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wd,
    input  logic                      mem_ready,
    input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          miss_count
);

    localparam int unsigned OFF_W     = $clog2(BLOCK_WORDS);
    localparam int unsigned OFF_SW    = (OFF_W == 0) ? 1 : OFF_W;
    localparam int unsigned IDX_W     = $clog2(SETS);
    localparam int unsigned TAG_W     = 30 - OFF_W - IDX_W;
    localparam logic [31:0] LINE_MASK = ~((32'(BLOCK_WORDS) << 2) - 32'd1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

    state_e             state_q, state_d;
    logic               done_q, done_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wd_q, mem_wd_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS][BLOCK_WORDS];

    logic [OFF_SW-1:0]  off;
    logic [IDX_W-1:0]   idx, fill_idx;
    logic [TAG_W-1:0]   tag, fill_tag;
    logic               lookup_hit;
    logic               issue_rd, issue_wr, fill_done, count_hit;

    assign off      = (OFF_W == 0) ? '0 : OFF_SW'(A >> 2);
    assign idx      = IDX_W'(A >> (2 + OFF_W));
    assign tag      = TAG_W'(A >> (2 + OFF_W + IDX_W));
    // Refill targets the latched line address, not the (held) pipeline address.
    assign fill_idx = IDX_W'(mem_addr_q >> (2 + OFF_W));
    assign fill_tag = TAG_W'(mem_addr_q >> (2 + OFF_W + IDX_W));

    assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
    assign HIT        = lookup_hit && (rd_en || wr_en) && (state_q == IDLE);
    assign RD         = HIT ? data_q[idx][off] : '0;

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wd     = mem_wd_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        STALL      = 1'b0;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        fill_done  = 1'b0;
        count_hit  = 1'b0;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        case (state_q)
            IDLE: begin
                // done_q marks the cycle the completed store is still on the inputs.
                if (wr_en) begin
                    if (!done_q) begin
                        STALL    = 1'b1;
                        issue_wr = 1'b1;
                        state_d  = WRITE;
                    end
                end else if (rd_en) begin
                    if (lookup_hit) begin
                        count_hit = 1'b1;
                    end else begin
                        STALL    = 1'b1;
                        issue_rd = 1'b1;
                        state_d  = FILL;
                    end
                end
            end
            FILL: begin
                STALL = 1'b1;
                if (mem_ready) begin
                    fill_done = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                STALL = 1'b1;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue_rd) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = A & LINE_MASK;
        end
        if (issue_wr) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = A & ~32'h3;
            mem_wd_d   = WD;
        end
        if (count_hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 1'b1;
        if (issue_rd && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if (fill_done) valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[fill_idx] <= fill_tag;
            for (int unsigned w = 0; w < BLOCK_WORDS; w++) begin
                data_q[fill_idx][OFF_SW'(w)] <= mem_rdata[32*w +: 32];
            end
        end else if (issue_wr && lookup_hit) begin
            data_q[idx][off] <= WD;
        end
    end

endmodule

// File: tb/tb_d_cache_wt.sv
// Bench for d_cache_wt: directed scenarios plus random loads/stores against a
// transaction-level model (cache is transparent over a flat memory).
module tb_d_cache_wt;

    localparam int L  = 3;
    localparam int BW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en, wr_en;
    logic [31:0]  A, WD;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    logic [31:0]  RD, mem_addr, mem_wd;
    logic         HIT, STALL, mem_req, mem_we;
    logic [15:0]  hit_count, miss_count;

    logic [31:0]  RD2, mem_addr2, mem_wd2;
    logic         HIT2, STALL2, mem_req2, mem_we2;
    logic [1:0]   hit_count2, miss_count2;

    d_cache_wt #(.SETS(16), .BLOCK_WORDS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .A(A), .WD(WD),
        .RD(RD), .HIT(HIT), .STALL(STALL), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    d_cache_wt #(.SETS(16), .BLOCK_WORDS(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .A(A), .WD(WD),
        .RD(RD2), .HIT(HIT2), .STALL(STALL2), .mem_req(mem_req2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wd(mem_wd2), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .hit_count(hit_count2), .miss_count(miss_count2)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [512];
    logic [31:0] ref_mem [512];
    bit          ref_v   [16];
    int unsigned ref_tag [16];
    int unsigned ref_hits, ref_misses;
    int          req_cnt;
    int          n_checks, n_pass;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [31:0] sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic mem_drive(input bit spurious);
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        mem_ready = 1'b0;
        if (mem_req) begin
            req_cnt++;
            if (req_cnt == L) begin
                mem_ready = 1'b1;
                req_cnt   = 0;
                if (mem_we) mem[mem_addr[10:2]] = mem_wd;
                else for (int k = 0; k < BW; k++) mem_rdata[32*k +: 32] = mem[{mem_addr[10:4], 2'(k)}];
            end
        end else begin
            req_cnt   = 0;
            mem_ready = spurious;
        end
    endtask

    task automatic check_counters();
        chk("hit_cnt", hit_count, sat(ref_hits, 65535));
        chk("miss_cnt", miss_count, sat(ref_misses, 65535));
        chk("hit_cnt_sat", hit_count2, sat(ref_hits, 3));
        chk("miss_cnt_sat", miss_count2, sat(ref_misses, 3));
    endtask

    task automatic do_op(input bit we, input bit re, input logic [31:0] addr, input logic [31:0] wd);
        int unsigned set_i, tg;
        bit hit_exp, done;
        int stalls, stalls2, exp_st;
        set_i   = (addr >> 4) & 32'hF;
        tg      = addr >> 8;
        hit_exp = ref_v[set_i] && (ref_tag[set_i] == tg);
        exp_st  = (we || !hit_exp) ? L + 1 : 0;
        rd_en = re; wr_en = we; A = addr; WD = wd;
        stalls = 0; stalls2 = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_drive(1'b0);
            #1;
            if (STALL2) stalls2++;
            if (STALL) begin
                stalls++;
                if (mem_req) begin
                    chk("mem_we", mem_we, we);
                    chk("mem_addr", mem_addr, we ? (addr & ~32'h3) : (addr & ~32'hF));
                    if (we) chk("mem_wd", mem_wd, wd);
                end
                @(posedge clk); @(negedge clk);
            end else begin
                done = 1;
            end
        end
        chk("stall_len", stalls, exp_st);
        chk("stall_len_sat", stalls2, exp_st);
        if (we) begin
            chk("hit_st", HIT, hit_exp);
            chk("rd_st", RD, hit_exp ? wd : 32'h0);
            ref_mem[addr[10:2]] = wd;
        end else begin
            chk("hit_ld", HIT, 1'b1);
            chk("rd_ld", RD, ref_mem[addr[10:2]]);
            chk("rd_ld_sat", RD2, ref_mem[addr[10:2]]);
            if (!hit_exp) begin
                ref_v[set_i]   = 1'b1;
                ref_tag[set_i] = tg;
                ref_misses++;
            end
            ref_hits++;
        end
        @(posedge clk); @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        check_counters();
    endtask

    task automatic idle_op();
        rd_en = 1'b0; wr_en = 1'b0; A = $urandom; WD = $urandom;
        mem_drive(1'($urandom_range(0, 1)));
        #1;
        chk("idle_stall", STALL, 1'b0);
        chk("idle_hit", HIT, 1'b0);
        chk("idle_rd", RD, 32'h0);
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned m0, r;
        logic [31:0] addr;
        n_checks = 0; n_pass = 0; req_cnt = 0;
        ref_hits = 0; ref_misses = 0;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; A = '0; WD = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) begin ref_v[i] = 1'b0; ref_tag[i] = 0; end
        for (int i = 0; i < 512; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        mem[0] = 32'hAAAAAAAA; mem[1] = 32'hBBBBBBBB; mem[2] = 32'hCCCCCCCC; mem[3] = 32'hDDDDDDDD;
        for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];

        #3;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        chk("rst_stall", STALL, 1'b0);
        check_counters();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_op(1'b0, 1'b1, 32'h8, 32'h0);
        chk("tp_miss1", miss_count, 32'd1);
        chk("tp_hit1", hit_count, 32'd1);
        do_op(1'b0, 1'b1, 32'h0, 32'h0);
        do_op(1'b0, 1'b1, 32'h4, 32'h0);
        do_op(1'b0, 1'b1, 32'hC, 32'h0);
        chk("tp_rd_c", ref_mem[3], 32'hDDDDDDDD);

        do_op(1'b1, 1'b0, 32'h4, 32'h12345678);
        do_op(1'b0, 1'b1, 32'h4, 32'h0);
        chk("tp_mem4", mem[1], 32'h12345678);

        do_op(1'b1, 1'b0, 32'h100, 32'hCAFEF00D);
        m0 = ref_misses;
        do_op(1'b0, 1'b1, 32'h100, 32'h0);
        chk("tp_store_noalloc", miss_count, m0 + 1);

        m0 = ref_misses;
        do_op(1'b0, 1'b1, 32'h0, 32'h0);
        do_op(1'b0, 1'b1, 32'h100, 32'h0);
        do_op(1'b0, 1'b1, 32'h0, 32'h0);
        chk("tp_conflict", miss_count, m0 + 3);

        // abandon a refill with an asynchronous reset
        rd_en = 1'b1; A = 32'h2C0;
        mem_drive(1'b0); #1;
        chk("rf_stall", STALL, 1'b1);
        @(posedge clk); @(negedge clk);
        mem_drive(1'b0);
        @(posedge clk); @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rf_mem_req", mem_req, 1'b0);
        chk("rf_mem_req_sat", mem_req2, 1'b0);
        chk("rf_hit_cnt", hit_count, 32'h0);
        chk("rf_miss_cnt", miss_count, 32'h0);
        for (int i = 0; i < 16; i++) ref_v[i] = 1'b0;
        ref_hits = 0; ref_misses = 0; req_cnt = 0;
        mem_ready = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op(1'b0, 1'b1, 32'h2C0, 32'h0);
        chk("rf_remiss", miss_count, 32'd1);

        for (int n = 0; n < 300; n++) begin
            r    = $urandom_range(0, 9);
            addr = 32'($urandom_range(0, 511)) << 2;
            if (r < 6)      do_op(1'b0, 1'b1, addr, 32'h0);
            else if (r < 9) do_op(1'b1, 1'($urandom_range(0, 1)), addr, $urandom);
            else            idle_op();
        end

        for (int i = 0; i < 512; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
